// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-stage load/store unit between the EX/MEM pipeline register and the
// data-memory bus. A legal, aligned request seen in IDLE is latched and
// issued as a word-aligned bus transaction with byte enables. The pipeline
// is stalled until the memory acknowledges or the timeout expires. Load data
// is lane-extracted and sign/zero-extended into ReadData.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   MemRead, MemWrite     load / store request from EX/MEM
//   funct3                access size/sign (B, H, W, BU, HU)
//   ALUout                byte address
//   WriteData             store data, right-aligned
//   ReadData              extended load result, held until the next load completes
//   Stall                 freeze IF/ID/EX/MEM while high
//   AccessErr             one-cycle pulse: misaligned or illegal access
//   BusErr                one-cycle pulse: bus timeout
//   mem_req/we/addr/be/wdata   bus request, held stable while in REQ
//   mem_ack, mem_rdata    one-cycle completion with read data
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUout,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter holds the number of REQ cycles already completed, so the
    // last allowed REQ cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  f3_p1;
    logic [1:0]  lane_p1;

    logic        req_any;
    logic        illegal;
    logic        misalign;
    logic        accept;
    logic        reject;
    logic        tmo;
    logic [35:0] st_fmt;

    // Store formatting: returns {be, wdata}. Loads always read the full word.
    function automatic logic [35:0] fmt_store(input logic        is_store,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] data;
        be   = 4'b1111;
        data = 32'd0;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    be   = 4'b0001 << off;
                    data = {4{wd[7:0]}};
                end
                2'b01: begin
                    be   = off[1] ? 4'b1100 : 4'b0011;
                    data = {2{wd[15:0]}};
                end
                default: begin
                    be   = 4'b1111;
                    data = wd;
                end
            endcase
        end
        return {be, data};
    endfunction

    // Lane extraction and extension of a returned read word.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Request qualification (only acted on in IDLE)
    always_comb begin
        req_any  = MemRead | MemWrite;
        illegal  = (MemRead & MemWrite)
                 | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
                 | (MemWrite & ((funct3 == 3'b100) | (funct3 == 3'b101)));
        misalign = (((funct3 == 3'b001) | (funct3 == 3'b101)) & ALUout[0])
                 | ((funct3 == 3'b010) & (ALUout[1:0] != 2'b00));
        accept   = req_any & ~illegal & ~misalign;
        reject   = req_any & (illegal | misalign);
        tmo      = (cnt == TMO_LAST);
        st_fmt   = fmt_store(MemWrite, funct3, ALUout[1:0], WriteData);
    end

    // Next state and stall
    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    Stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_ack || tmo) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Keep the pipeline free while reset is held, even if a stale
        // request is still presented.
        if (!rst_n) begin
            Stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus side, latched request fields and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData  <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            AccessErr <= 1'b0;
            BusErr    <= 1'b0;
            cnt       <= 8'd0;
            f3_p1     <= 3'd0;
            lane_p1   <= 2'd0;
        end else begin
            AccessErr <= 1'b0;
            BusErr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {ALUout[31:2], 2'b00};
                        mem_be    <= st_fmt[35:32];
                        mem_wdata <= st_fmt[31:0];
                        f3_p1     <= funct3;
                        lane_p1   <= ALUout[1:0];
                        cnt       <= 8'd0;
                    end else if (reject) begin
                        AccessErr <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadData <= load_extend(f3_p1, lane_p1, mem_rdata);
                        end
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        BusErr  <= 1'b1;
                        if (!mem_we) begin
                            ReadData <= 32'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUout;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AccessErr;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUout(ALUout), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
        .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected load result from the byte/halfword rules, using shifts and masks.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // One instruction in MEM. n = REQ cycle (1-based) carrying the ack, 0 = never.
    // Entered and left at posedge+1 with the unit idle.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int n, input logic [31:0] rdata);
        bit          bad;
        int          off;
        int          stalls;
        int          rc;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        off = int'(addr[1:0]);
        bad = (rd && wr) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
              (wr && (f3 == 3'd4 || f3 == 3'd5)) ||
              ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) != 0) ||
              (f3 == 3'd2 && off != 0);
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUout = addr; WriteData = wd;
        #1;
        if (bad) begin
            chk("err_stall", 32'(Stall), 32'd0);
            step();
            chk("err_pulse", 32'(AccessErr), 32'd1);
            chk("err_noreq", 32'(mem_req), 32'd0);
            chk("err_stall2", 32'(Stall), 32'd0);
            MemRead = 1'b0; MemWrite = 1'b0;
            step();
            chk("err_pulse_end", 32'(AccessErr), 32'd0);
            chk("err_noreq2", 32'(mem_req), 32'd0);
            chk("err_rdata", ReadData, exp_rd);
            return;
        end
        ebe = 4'hF; ewd = wd;
        if (wr && (f3 == 3'd0)) begin ebe = 4'(1 << off); ewd = (wd & 32'hFF) * 32'h01010101; end
        if (wr && (f3 == 3'd1)) begin ebe = 4'(3 << off); ewd = (wd & 32'hFFFF) * 32'h00010001; end
        chk("idle_stall", 32'(Stall), 32'd1);
        stalls = 1;
        step();
        mem_rdata = rdata;
        #1;
        chk("req", 32'(mem_req), 32'd1);
        chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("be", 32'(mem_be), 32'(ebe));
        chk("we", 32'(mem_we), 32'(wr));
        if (wr) chk("wdata", mem_wdata, ewd);
        rc = 1;
        while (Stall === 1'b1 && rc <= 300) begin
            stalls++;
            if (mem_req !== 1'b1) chk("req_held", 32'(mem_req), 32'd1);
            mem_ack = (rc == n);
            @(posedge clk);
            #1 mem_ack = 1'b0;
            #1;
            rc++;
        end
        if (rc > 300) chk("stall_timeout", 32'd1, 32'd0);
        if (rd) exp_rd = (n > 0) ? load_val(f3, off, rdata) : 32'd0;
        chk("stall_len", 32'(stalls), (n > 0) ? 32'(n + 1) : 32'(TMO + 1));
        chk("rdata", ReadData, exp_rd);
        chk("buserr", 32'(BusErr), (n > 0) ? 32'd0 : 32'd1);
        chk("done_req", 32'(mem_req), 32'd0);
        // stray ack in DONE with the request still presented
        mem_ack = 1'b1; mem_rdata = ~rdata;
        step();
        mem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk("idle_stall_after", 32'(Stall), 32'd0);
        chk("idle_req_after", 32'(mem_req), 32'd0);
        chk("buserr_end", 32'(BusErr), 32'd0);
        chk("rdata_hold", ReadData, exp_rd);
        step();
    endtask

    initial begin
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        ALUout = 32'd0; WriteData = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_errs", {30'd0, AccessErr, BusErr}, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        rst_n = 1'b1;
        step();

        access(1, 0, 3'd2, 32'h100, 32'd0, 1, 32'hDEADBEEF);
        access(1, 0, 3'd0, 32'h103, 32'd0, 1, 32'h80123456);
        access(1, 0, 3'd4, 32'h103, 32'd0, 2, 32'h80123456);
        access(1, 0, 3'd1, 32'h102, 32'd0, 1, 32'h80011234);
        access(0, 1, 3'd0, 32'h201, 32'h000000A5, 3, 32'h0);
        access(0, 1, 3'd1, 32'h202, 32'h1234BEEF, 1, 32'h0);
        access(1, 0, 3'd2, 32'h102, 32'd0, 1, 32'h0);
        access(0, 1, 3'd1, 32'h101, 32'd0, 1, 32'h0);
        access(1, 1, 3'd2, 32'h100, 32'd0, 1, 32'h0);
        access(1, 0, 3'd2, 32'h300, 32'd0, 0, 32'h12345678);
        access(1, 0, 3'd2, 32'h104, 32'd0, 1, 32'h5A5A0F0F);

        // reset on the 2nd REQ cycle
        MemRead = 1'b1; funct3 = 3'd2; ALUout = 32'h400;
        step();
        step();
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0; MemRead = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_errs", {30'd0, AccessErr, BusErr}, 32'd0);
        chk("rst_mid_rdata", ReadData, 32'd0);
        exp_rd = 32'd0;
        step();
        rst_n = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        #1;
        chk("late_ack_rdata", ReadData, 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_stall", 32'(Stall), 32'd0);
        step();

        for (int i = 0; i < 80; i++) begin
            int r;
            bit rd, wr;
            int n;
            r  = int'($urandom_range(0, 9));
            rd = (r == 0) || (r <= 5);
            wr = (r == 0) || (r > 5);
            n  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, n, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
